// File: rtl/mux10_1_e_high.sv
// mux10_1_e_high: enabled 10:1 lane selector with optional output register and illegal-select flag
module mux10_1_e_high #(
  parameter int WIDTH = 1,
  parameter bit REG_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10*WIDTH-1:0] I,
  input  logic [3:0]         S,
  input  logic               E,
  output logic [WIDTH-1:0]   Y,
  output logic               sel_err
);
  logic [WIDTH-1:0] lanes [10];
  logic [WIDTH-1:0] next_y;
  logic             next_err;
  for (genvar k = 0; k < 10; k++) begin : g_lane
    assign lanes[k] = I[k*WIDTH +: WIDTH];
  end
  // Index by S so an X on an unselected lane can never reach Y
  always_comb begin
    next_err = E && (S > 4'd9);
    next_y   = (E && (S <= 4'd9)) ? lanes[S] : '0;
  end
  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        Y       <= '0;
        sel_err <= 1'b0;
      end else begin
        Y       <= next_y;
        sel_err <= next_err;
      end
    end
  end else begin : g_comb
    assign Y       = next_y;
    assign sel_err = next_err;
  end
endmodule

// File: tb/tb_mux10_1_e_high.sv
// tb_mux10_1_e_high: directed checks of registered, combinational and 8-bit-wide selector variants
module tb_mux10_1_e_high;
  logic        clk = 0;
  logic        rst = 1;
  logic [9:0]  i1 = '0;
  logic [9:0]  tog;
  logic [9:0]  din;
  logic        tog_mode = 0;
  logic [79:0] i8 = '0;
  logic [3:0]  s = '0;
  logic        e = 0;
  logic        y_r, err_r, y_c, err_c, err_8;
  logic [7:0]  y_8;
  int          passed = 0;
  int          total = 0;
  logic        exp_hold;
  logic        sweep_exp [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  // Lane k toggles every 5*(10-k) ns, phase-shifted 2 ns off the clock edges
  for (genvar k = 0; k < 10; k++) begin : g_tog
    logic t = 0;
    initial begin
      #2;
      forever #(5*(10-k)) t = ~t;
    end
    assign tog[k] = t;
  end

  assign din = tog_mode ? tog : i1;

  mux10_1_e_high #(.WIDTH(1), .REG_OUT(1)) dut_r (
    .clk(clk), .rst(rst), .I(din), .S(s), .E(e), .Y(y_r), .sel_err(err_r));
  mux10_1_e_high #(.WIDTH(1), .REG_OUT(0)) dut_c (
    .clk(clk), .rst(rst), .I(din), .S(s), .E(e), .Y(y_c), .sel_err(err_c));
  mux10_1_e_high #(.WIDTH(8), .REG_OUT(1)) dut_8 (
    .clk(clk), .rst(rst), .I(i8), .S(s), .E(e), .Y(y_8), .sel_err(err_8));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: outputs forced low asynchronously
    e = 1; s = 4'd3; i1 = 10'b0000001000;
    #1;
    chk("rst_y", {7'b0, y_r}, 8'h00);
    chk("rst_err", {7'b0, err_r}, 8'h00);
    cyc();
    chk("rst_hold_y", {7'b0, y_r}, 8'h00);
    rst = 0;
    cyc();
    chk("rst_release_y", {7'b0, y_r}, 8'h01);
    rst = 1;
    #1;
    chk("rst_async_y", {7'b0, y_r}, 8'h00);
    cyc();
    chk("rst_mid_hold_y", {7'b0, y_r}, 8'h00);
    rst = 0;
    // Disable sweep
    e = 0; i1 = 10'h3FF;
    for (int k = 0; k < 16; k++) begin
      s = k[3:0];
      #1;
      chk("dis_y_c", {7'b0, y_c}, 8'h00);
      chk("dis_err_c", {7'b0, err_c}, 8'h00);
      cyc();
      chk("dis_y_r", {7'b0, y_r}, 8'h00);
      chk("dis_err_r", {7'b0, err_r}, 8'h00);
    end
    // Select sweep
    e = 1; i1 = 10'b1010011001;
    for (int k = 0; k < 10; k++) begin
      s = k[3:0];
      #1;
      chk("sel_y_c", {7'b0, y_c}, {7'b0, sweep_exp[k]});
      cyc();
      chk("sel_y_r", {7'b0, y_r}, {7'b0, sweep_exp[k]});
      chk("sel_err_r", {7'b0, err_r}, 8'h00);
    end
    // X on unselected lanes must not reach Y
    i1 = 10'bxxxxxx1xxx; s = 4'd3;
    #1;
    chk("xlane_y_c", {7'b0, y_c}, 8'h01);
    cyc();
    chk("xlane_y_r", {7'b0, y_r}, 8'h01);
    // Independently toggling lanes
    tog_mode = 1;
    for (int k = 0; k < 10; k++) begin
      s = k[3:0];
      for (int n = 0; n < 50; n++) begin
        cyc();
        exp_hold = tog[k];
        chk("tog_y_r_edge", {7'b0, y_r}, {7'b0, exp_hold});
        chk("tog_y_c_edge", {7'b0, y_c}, {7'b0, tog[k]});
        #3;
        chk("tog_y_r_hold", {7'b0, y_r}, {7'b0, exp_hold});
        chk("tog_y_c_late", {7'b0, y_c}, {7'b0, tog[k]});
      end
    end
    tog_mode = 0;
    // Illegal select codes
    e = 1; i1 = 10'h3FF;
    for (int k = 10; k < 16; k++) begin
      s = k[3:0];
      #1;
      chk("ill_y_c", {7'b0, y_c}, 8'h00);
      chk("ill_err_c", {7'b0, err_c}, 8'h01);
      cyc();
      chk("ill_y_r", {7'b0, y_r}, 8'h00);
      chk("ill_err_r", {7'b0, err_r}, 8'h01);
    end
    s = 4'd9;
    #1;
    chk("s9_y_c", {7'b0, y_c}, 8'h01);
    chk("s9_err_c", {7'b0, err_c}, 8'h00);
    chk("s9_y_r_latency", {7'b0, y_r}, 8'h00);
    chk("s9_err_r_latency", {7'b0, err_r}, 8'h01);
    cyc();
    chk("s9_y_r", {7'b0, y_r}, 8'h01);
    chk("s9_err_r", {7'b0, err_r}, 8'h00);
    // Wide lanes
    for (int k = 0; k < 10; k++) i8[k*8 +: 8] = 8'h10 + 8'(k);
    s = 4'd7;
    cyc();
    cyc();
    chk("wide_s7", y_8, 8'h17);
    s = 4'd0;
    cyc();
    chk("wide_s0", y_8, 8'h10);
    s = 4'd12;
    cyc();
    chk("wide_ill_y", y_8, 8'h00);
    chk("wide_ill_err", {7'b0, err_8}, 8'h01);
    s = 4'd9;
    cyc();
    chk("wide_s9", y_8, 8'h19);
    e = 0;
    cyc();
    chk("wide_dis", y_8, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
